// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with architectural HI/LO registers.
//
// Executes mult/multu/div/divu over a fixed multi-cycle latency and handles
// mthi/mtlo as single-edge writes. HI/LO keep their old values for the whole
// busy window. Both are written together on the edge where the latency
// counter steps from 1 to 0.
//
// Optional feature: define MD_UNIT_MADD_EN to enable md_op=7 (madd). madd is a
// signed multiply-accumulate into {hi,lo}. When the macro is undefined, op 7
// is ignored.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous active-low reset; clears all state
//   start      request strobe, qualified by md_op/rs_val/rt_val
//   md_op      0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd
//   rs_val     dividend / multiplicand / mthi-mtlo source
//   rt_val     divisor / multiplier
//   hi, lo     architectural HI and LO registers
//   busy       multi-cycle operation in flight
//   stall_req  busy, or a multi-cycle op being requested this cycle

module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6,
        OpMadd  = 3'd7
    } md_op_e;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_op_e          op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    md_op_e          req_op;
    logic            req_long;

    // Datapath results, all computed from the latched operands.
    logic [63:0]     prod_s;
    logic [63:0]     prod_u;
    logic            div_signed;
    logic [31:0]     num_mag;
    logic [31:0]     den_mag;
    logic [31:0]     den_safe;
    logic [31:0]     quo_mag;
    logic [31:0]     rem_mag;
    logic [31:0]     quo;
    logic [31:0]     rem;
`ifdef MD_UNIT_MADD_EN
    logic [63:0]     madd_sum;
`endif

    assign req_op = md_op_e'(md_op);

    // Ops that occupy the unit for more than one cycle.
    always_comb begin
        req_long = 1'b0;
        case (req_op)
            OpMult, OpMultu, OpDiv, OpDivu: req_long = 1'b1;
`ifdef MD_UNIT_MADD_EN
            OpMadd:                         req_long = 1'b1;
`else
            OpMadd:                         req_long = 1'b0;
`endif
            default:                        req_long = 1'b0;
        endcase
    end

    always_comb begin
        // The low 64 bits of a product of sign-extended operands give the signed product.
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
`ifdef MD_UNIT_MADD_EN
        madd_sum = {hi_q, lo_q} + prod_s;
`endif
    end

    // Signed division is done on magnitudes and the signs are restored afterwards.
    // 0x80000000 / -1 then gives quotient 0x80000000 and remainder 0.
    always_comb begin
        div_signed = (op_q == OpDiv);
        num_mag    = (div_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
        den_mag    = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
        // A zero divisor never writes back, so substituting 1 only keeps the divider defined.
        den_safe   = (den_mag == 32'd0) ? 32'd1 : den_mag;
        quo_mag    = num_mag / den_safe;
        rem_mag    = num_mag % den_safe;
        quo        = (div_signed && (a_q[31] ^ b_q[31])) ? (~quo_mag + 32'd1) : quo_mag;
        rem        = (div_signed && a_q[31]) ? (~rem_mag + 32'd1) : rem_mag;
    end

    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (busy_q) begin
            // Requests arriving while busy are dropped; upstream holds them via stall_req.
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                case (op_q)
                    OpMult: begin
                        hi_d = prod_s[63:32];
                        lo_d = prod_s[31:0];
                    end
                    OpMultu: begin
                        hi_d = prod_u[63:32];
                        lo_d = prod_u[31:0];
                    end
                    OpDiv, OpDivu: begin
                        if (b_q != 32'd0) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end
`ifdef MD_UNIT_MADD_EN
                    OpMadd: begin
                        hi_d = madd_sum[63:32];
                        lo_d = madd_sum[31:0];
                    end
`endif
                    default: ;
                endcase
            end
        end else if (start) begin
            if (req_long) begin
                op_d   = req_op;
                a_d    = rs_val;
                b_d    = rt_val;
                busy_d = 1'b1;
                cnt_d  = (req_op == OpDiv || req_op == OpDivu) ? CntW'(DIV_CYCLES)
                                                               : CntW'(MULT_CYCLES);
            end else if (req_op == OpMthi) begin
                hi_d = rs_val;
            end else if (req_op == OpMtlo) begin
                lo_d = rs_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OpNone;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign stall_req = busy_q | (start & req_long);

endmodule
